// File: rtl/tinker_fetch_unit.sv
// Tinker instruction fetch front end: PC, imem req/ack fetch FSM, FWFT instruction buffer, redirects.
// Define TINKER_FETCH_ALIGN_CHECK_EN to turn misaligned redirects into a sticky fetch fault.
module tinker_fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [63:0] RESET_PC   = 64'h2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      drain_addr_q, drain_addr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      mem_pc_q   [FIFO_DEPTH];
  logic [31:0]      mem_word_q [FIFO_DEPTH];
  logic             fault_q, fault_d;

  logic        redirect_take;
  logic        misaligned;
  logic        flush;
  logic        push;
  logic        pop;
  logic        can_issue;
  logic [63:0] redirect_aligned;

  // Low address bits are dropped rather than honoured; the fault build reports them instead.
  assign redirect_aligned = redirect_pc & ~64'd3;

`ifdef TINKER_FETCH_ALIGN_CHECK_EN
  // Once faulted, the unit is frozen: later redirects are not even seen.
  assign redirect_take = redirect_valid && !fault_q;
  assign misaligned    = redirect_take && (redirect_pc[1:0] != 2'b00);
  assign fault_d       = fault_q | misaligned;
`else
  assign redirect_take = redirect_valid;
  assign misaligned    = 1'b0;
  assign fault_q       = 1'b0;
  assign fault_d       = 1'b0;
`endif

  assign flush = redirect_take;

  assign imem_req    = (state_q != ST_IDLE);
  assign imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign inst_valid  = (count_q != '0);
  assign inst_out    = mem_word_q[rd_ptr_q];
  assign inst_pc     = mem_pc_q[rd_ptr_q];
  assign fetch_fault = fault_q;

  // A redirect discards whatever would have been pushed or popped in the same cycle.
  assign push = (state_q == ST_REQ) && imem_ack && !flush;
  assign pop  = inst_valid && inst_ready && !flush;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_take) begin
      if (!misaligned) pc_d = redirect_aligned;
    end else if (push) begin
      pc_d = pc_q + 64'd4;
    end
  end

  // Deciding on next-cycle occupancy lets a request start the cycle right after a pop or redirect.
  assign can_issue = (count_d < DEPTH_C) && !fault_d;

  always_comb begin
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    case (state_q)
      ST_IDLE: state_d = can_issue ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (redirect_take && !imem_ack) begin
          state_d      = ST_DRAIN;
          drain_addr_d = pc_q;
        end else if (imem_ack) begin
          state_d = can_issue ? ST_REQ : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) state_d = can_issue ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the buffer is reset because the head is visible even when empty and must read 0, never X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_pc_q   <= '{default: '0};
      mem_word_q <= '{default: '0};
    end else if (push) begin
      mem_pc_q[wr_ptr_q]   <= pc_q;
      mem_word_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef TINKER_FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
`endif

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Bench for tinker_fetch_unit: directed vector table, hand-written redirect/fault/wrap sequences,
// and randomized traffic checked against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_tinker_fetch_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] key = 32'h0;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        rdy;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_out;
    logic [63:0] exp_pc;
  } vec_t;
  vec_t vecs[$];

  // Model state for the random phase
  int          m_count;
  logic [63:0] m_fetch;
  logic [63:0] m_deliver;
  logic        m_stale;
  logic [63:0] m_stale_addr;

  always #5 clk = ~clk;

  tinker_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ key;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are then sampled 1ns later.
  task automatic step(input logic rst, input logic ack, input logic rdy,
                      input logic rv, input logic [63:0] rpc);
    @(negedge clk);
    reset          = rst;
    imem_ack       = ack;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    imem_rdata = mem_word(imem_addr);
  endtask

  // Leaves the bench at the sample point of cycle 0 (first cycle after release).
  task automatic reset_dut();
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic add(input logic rst, input logic ack, input logic rdy, input logic req,
                     input logic [63:0] addr, input logic vld, input logic [31:0] out,
                     input logic [63:0] pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdy = rdy; v.exp_req = req; v.exp_addr = addr;
    v.exp_valid = vld; v.exp_out = out; v.exp_pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        a, r, rv, fire, epop;
    logic [63:0] rt;
    int          ack_pct, rdy_pct;

    reset = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 64'h0; imem_rdata = 32'h0;

    // ---------------- directed vector table (word = addr[31:0]) ----------------
    // A: memory and decoder always ready -> one instruction per cycle, first in cycle 2
    add(1, 0, 0, 0, 64'h2000, 0, 32'h0,    64'h0);
    add(0, 1, 1, 0, 64'h2000, 0, 32'h0,    64'h0);
    add(0, 1, 1, 1, 64'h2000, 0, 32'h0,    64'h0);
    add(0, 1, 1, 1, 64'h2004, 1, 32'h2000, 64'h2000);
    add(0, 1, 1, 1, 64'h2008, 1, 32'h2004, 64'h2004);
    add(0, 1, 1, 1, 64'h200c, 1, 32'h2008, 64'h2008);
    add(0, 1, 1, 1, 64'h2010, 1, 32'h200c, 64'h200c);
    // B: decoder stalled -> four acks then idle; one pop reopens fetch at 0x2010
    add(1, 0, 0, 0, 64'h2000, 0, 32'h0,    64'h0);
    add(0, 1, 0, 0, 64'h2000, 0, 32'h0,    64'h0);
    add(0, 1, 0, 1, 64'h2000, 0, 32'h0,    64'h0);
    add(0, 1, 0, 1, 64'h2004, 1, 32'h2000, 64'h2000);
    add(0, 1, 0, 1, 64'h2008, 1, 32'h2000, 64'h2000);
    add(0, 1, 0, 1, 64'h200c, 1, 32'h2000, 64'h2000);
    add(0, 1, 0, 0, 64'h0,    1, 32'h2000, 64'h2000);
    add(0, 1, 1, 0, 64'h0,    1, 32'h2000, 64'h2000);
    add(0, 1, 0, 1, 64'h2010, 1, 32'h2004, 64'h2004);
    add(0, 1, 0, 0, 64'h0,    1, 32'h2004, 64'h2004);
    add(0, 0, 1, 0, 64'h0,    1, 32'h2004, 64'h2004);
    add(0, 0, 0, 1, 64'h2014, 1, 32'h2008, 64'h2008);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ack, vecs[i].rdy, 1'b0, 64'h0);
      check($sformatf("vec%0d.req", i), imem_req, vecs[i].exp_req);
      if (vecs[i].exp_req || vecs[i].rst)
        check($sformatf("vec%0d.addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d.valid", i), inst_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid || vecs[i].rst) begin
        check($sformatf("vec%0d.out", i), inst_out, vecs[i].exp_out);
        check($sformatf("vec%0d.pc", i), inst_pc, vecs[i].exp_pc);
      end
      if (vecs[i].rst) check($sformatf("vec%0d.fault", i), fetch_fault, 1'b0);
    end

    key = 32'hC0DE_0000;

    // ---------------- redirect while a slow request is outstanding ----------------
    reset_dut();
    step(0, 0, 0, 1, 64'h4000);
    check("drain.c1.req", imem_req, 1'b1);
    check("drain.c1.addr", imem_addr, 64'h2000);
    step(0, 0, 0, 0, 64'h0);
    check("drain.c2.addr", imem_addr, 64'h2000);
    check("drain.c2.valid", inst_valid, 1'b0);
    step(0, 1, 1, 0, 64'h0);
    check("drain.c3.addr", imem_addr, 64'h2000);
    step(0, 1, 1, 0, 64'h0);
    check("drain.c4.req", imem_req, 1'b1);
    check("drain.c4.addr", imem_addr, 64'h4000);
    check("drain.c4.valid", inst_valid, 1'b0);
    step(0, 0, 1, 0, 64'h0);
    check("drain.c5.valid", inst_valid, 1'b1);
    check("drain.c5.pc", inst_pc, 64'h4000);
    check("drain.c5.out", inst_out, mem_word(64'h4000));

    // ---------------- redirect + ack + pop with two entries buffered ----------------
    reset_dut();
    step(0, 1, 0, 0, 64'h0);
    step(0, 1, 0, 0, 64'h0);
    step(0, 1, 1, 1, 64'h4000);
    check("flush.pre.pc", inst_pc, 64'h2000);
    check("flush.pre.addr", imem_addr, 64'h2008);
    step(0, 0, 1, 0, 64'h0);
    check("flush.valid", inst_valid, 1'b0);
    check("flush.addr", imem_addr, 64'h4000);
    step(0, 1, 1, 0, 64'h0);
    check("flush.valid2", inst_valid, 1'b0);
    step(0, 0, 1, 0, 64'h0);
    check("flush.head.pc", inst_pc, 64'h4000);
    check("flush.head.out", inst_out, mem_word(64'h4000));

    // ---------------- misaligned redirect ----------------
    reset_dut();
    step(0, 1, 0, 1, 64'h4002);
    check("mis.c1.addr", imem_addr, 64'h2000);
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
    step(0, 0, 0, 0, 64'h0);
    check("mis.fault", fetch_fault, 1'b1);
    check("mis.req", imem_req, 1'b0);
    check("mis.valid", inst_valid, 1'b0);
    step(0, 1, 1, 0, 64'h0);
    step(0, 1, 1, 1, 64'h5000);
    step(0, 1, 1, 0, 64'h0);
    check("mis.late.req", imem_req, 1'b0);
    check("mis.late.fault", fetch_fault, 1'b1);
    check("mis.late.valid", inst_valid, 1'b0);
`else
    step(0, 0, 0, 0, 64'h0);
    check("mis.fault", fetch_fault, 1'b0);
    check("mis.req", imem_req, 1'b1);
    check("mis.addr", imem_addr, 64'h4000);
    step(0, 1, 1, 0, 64'h0);
    step(0, 0, 1, 0, 64'h0);
    check("mis.head.pc", inst_pc, 64'h4000);
    check("mis.head.out", inst_out, mem_word(64'h4000));
`endif

    // ---------------- address wrap ----------------
    reset_dut();
    step(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 1, 1, 0, 64'h0);
    check("wrap.addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 1, 1, 0, 64'h0);
    check("wrap.addr1", imem_addr, 64'h0);
    check("wrap.pc0", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap.out0", inst_out, mem_word(64'hFFFF_FFFF_FFFF_FFFC));
    step(0, 1, 1, 0, 64'h0);
    check("wrap.addr2", imem_addr, 64'h4);
    check("wrap.pc1", inst_pc, 64'h0);
    check("wrap.out1", inst_out, mem_word(64'h0));
    step(0, 1, 1, 0, 64'h0);
    check("wrap.pc2", inst_pc, 64'h4);

    // ---------------- randomized traffic against the stream model ----------------
    key = $urandom();
    reset_dut();
    m_count = 0; m_fetch = RST_PC; m_deliver = RST_PC; m_stale = 1'b0; m_stale_addr = 64'h0;
    for (int k = 0; k < 3000; k++) begin
      ack_pct = ((k / 400) % 2 == 0) ? 45 : 95;
      rdy_pct = ((k / 300) % 3 == 0) ? 20 : 75;
      a  = ($urandom_range(0, 99) < ack_pct);
      r  = ($urandom_range(0, 99) < rdy_pct);
      rv = ($urandom_range(0, 99) < 4);
      rt = {32'h0, $urandom()};
      if ($urandom_range(0, 3) == 0) rt = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, rt[3:0]};
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
      rt[1:0] = 2'b00;
`endif
      step(0, a, r, rv, rt);

      // Expected view of this cycle
      if (m_stale) begin
        exp_req  = 1'b1;
        exp_addr = m_stale_addr;
      end else begin
        exp_req  = (m_count < DEPTH);
        exp_addr = m_fetch;
      end
      check("rnd.valid", inst_valid, (m_count != 0));
      if (m_count != 0) begin
        check("rnd.pc", inst_pc, m_deliver);
        check("rnd.out", inst_out, mem_word(m_deliver));
      end
      check("rnd.req", imem_req, exp_req);
      if (exp_req) check("rnd.addr", imem_addr, exp_addr);

      // Advance the model across the coming edge
      fire = exp_req && a;
      epop = (m_count != 0) && r;
      if (rv) begin
        if (exp_req && !a) begin
          if (!m_stale) m_stale_addr = exp_addr;
          m_stale = 1'b1;
        end else begin
          m_stale = 1'b0;
        end
        m_count   = 0;
        m_fetch   = rt & ~64'd3;
        m_deliver = rt & ~64'd3;
      end else begin
        if (fire) begin
          if (m_stale) m_stale = 1'b0;
          else begin
            m_count++;
            m_fetch = m_fetch + 64'd4;
          end
        end
        if (epop) begin
          m_count--;
          m_deliver = m_deliver + 64'd4;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
